// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared types, LED polarity constants and timing helper for the LED display
package led_pkg;

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    STATIC = 2'd1,
    BLINK  = 2'd2,
    SCAN   = 2'd3
  } mode_e;

  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  function automatic int tick_div(input int clk_hz, input int blink_hz);
    return clk_hz / (2 * blink_hz);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler producing a one-cycle tick every DIV clocks, with synchronous clear
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_display_ctrl.sv
// rtl/led_display_ctrl.sv - latches a value and drives an active-low LED bank with mode, PWM and change flag
module led_display_ctrl #(
  parameter int N_LEDS   = 6,
  parameter int DATA_W   = 4,
  parameter int CLK_HZ   = 27_000_000,
  parameter int BLINK_HZ = 2,
  parameter int PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   data,
  input  logic                data_valid,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic [N_LEDS-1:0]   leds
);

  import led_pkg::*;

  localparam int TICK_DIV = tick_div(CLK_HZ, BLINK_HZ);
  localparam int PW       = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam int FW       = $clog2(TICK_DIV + 1);
  localparam bit FLAG_EN  = (N_LEDS > DATA_W);

  logic [DATA_W-1:0]   data_q, data_d;
  mode_e               mode_q, mode_d;
  logic                phase_q, phase_d;
  logic [PW-1:0]       pos_q, pos_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [FW-1:0]       flag_q, flag_d;
  logic [N_LEDS-1:0]   leds_q, leds_d;

  logic              mode_chg;
  logic              tick;
  logic              gate;
  logic [N_LEDS-1:0] data_vec, flag_vec, scan_vec, pattern;

  assign mode_chg = (mode_e'(mode) != mode_q);

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (mode_chg),
    .tick  (tick)
  );

  always_comb begin
    data_d    = data_valid ? data : data_q;
    mode_d    = mode_e'(mode);
    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

    // A mode change restarts the blink/scan timing, overriding any tick on the same edge.
    phase_d = phase_q;
    pos_d   = pos_q;
    if (mode_chg) begin
      phase_d = 1'b0;
      pos_d   = '0;
    end else if (tick) begin
      phase_d = ~phase_q;
      pos_d   = (pos_q == PW'(N_LEDS - 1)) ? '0 : pos_q + PW'(1);
    end

    flag_d = flag_q;
    if (data_valid && (data != data_q)) begin
      flag_d = FW'(TICK_DIV);
    end else if (flag_q != '0) begin
      flag_d = flag_q - FW'(1);
    end
  end

  always_comb begin
    data_vec = N_LEDS'(data_q);
    flag_vec = (FLAG_EN && (flag_q != '0)) ? (N_LEDS'(1) << DATA_W) : '0;
    scan_vec = N_LEDS'(1) << pos_q;
    gate     = (&brightness) || (pwm_cnt_q < brightness);

    pattern = '0;
    case (mode_q)
      STATIC:  pattern = data_vec | flag_vec;
      BLINK:   pattern = (phase_q ? data_vec : '0) | flag_vec;
      SCAN:    pattern = scan_vec;
      default: pattern = '0;
    endcase

    leds_d = ~(pattern & {N_LEDS{gate}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      mode_q    <= OFF;
      phase_q   <= 1'b0;
      pos_q     <= '0;
      pwm_cnt_q <= '0;
      flag_q    <= '0;
      leds_q    <= {N_LEDS{LED_OFF}};
    end else begin
      data_q    <= data_d;
      mode_q    <= mode_d;
      phase_q   <= phase_d;
      pos_q     <= pos_d;
      pwm_cnt_q <= pwm_cnt_d;
      flag_q    <= flag_d;
      leds_q    <= leds_d;
    end
  end

  assign leds = leds_q;

endmodule
